pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline sequencing controller for the 5-stage CPU. It produces the enable and flush controls for PC, IF_ID, ID_EX, EX_MEM and MEM_WB from three sources:
- load-use hazards;
- branches taken in EX;
- a multi-cycle data-memory handshake.

It also halts the pipeline on a memory timeout and keeps saturating stall and flush statistics. Controls are combinational, so a stall takes effect at the next edge. State and counters are registered.

## Interface
- RW, 5: register-address width
- CW, 32: statistics counter width
- MAX_WAIT, 16: maximum consecutive not-ready cycles per memory access before halt (≥2)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_rs1, id_rs2  in  RW  source registers of the instruction in ID (IF_ID output)
- id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1 / rs2
- ex_mem_read  in  1  instruction in EX is a load (ID_EX output)
- ex_rd  in  RW  destination register of the EX instruction
- ex_br_taken  in  1  branch/jump in EX resolved taken; PC mux selects target
- mem_req  in  1  instruction in MEM accesses data memory (EX_MEM output)
- mem_ready  in  1  data memory completes the access this cycle
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  load enables
- if_id_flush, id_ex_flush, mem_wb_flush  out  1  load NOP (all-zero) at next edge; always asserted with the matching enable = 1
- halted  out  1  pipeline frozen after memory timeout
- stall_cnt  out  CW  cycles with a stall (load-use or memory)
- flush_cnt  out  CW  taken-branch flush events

## Operation
- States: RUN (reset state), MEM_WAIT, HALT. wait_cnt is an internal register sized for MAX_WAIT-1; reset value 0.
- mstall = mem_req & ~mem_ready & (state != HALT).
- lu = ex_mem_read & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
- Output priority, highest first:
  - HALT: all enables 0, all flushes 0, halted = 1.
  - mstall:
    - pc_en, if_id_en, id_ex_en, ex_mem_en = 0.
    - mem_wb_en = 1, mem_wb_flush = 1.
    - ex_br_taken and lu are ignored. Stages are held, so both are re-evaluated later.
  - ex_br_taken:
    - All enables 1.
    - if_id_flush = 1, id_ex_flush = 1.
    - lu is ignored because the ID instruction is squashed.
  - lu:
    - pc_en = 0, if_id_en = 0.
    - id_ex_en = 1, id_ex_flush = 1.
    - ex_mem_en = 1, mem_wb_en = 1.
  - Otherwise: all enables 1, all flushes 0.
- State transitions, RUN or MEM_WAIT:
  - If mstall and wait_cnt == MAX_WAIT-1: next state HALT.
  - Else if mstall: wait_cnt += 1, next state MEM_WAIT.
  - Else: wait_cnt = 0, next state RUN. This covers both mem_ready = 1 and mem_req dropping.
- HALT is left only by rst.
- Counters:
  - stall_cnt += 1 in each cycle with mstall or (lu & ~ex_br_taken) outside HALT.
  - flush_cnt += 1 in each cycle where the ex_br_taken flush row is selected.
  - Both counters saturate at all-ones.
- Reset: state RUN, wait_cnt 0, stall_cnt 0, flush_cnt 0, halted 0.
  - With rst held and all inputs 0, outputs are: all enables 1, all flushes 0.
  - rst mid-wait or in HALT returns to RUN on the same edge.

## Timing
- Enable, flush and halted outputs are combinational from current state and inputs. There is no cycle of latency from hazard to control.
- Load-use: exactly 1 bubble. After the edge, ID_EX holds a NOP, so ex_mem_read = 0 and lu clears.
- Taken branch: 2 bubbles (IF_ID and ID_EX both flushed on one edge).
- Memory access with ready after k not-ready cycles:
  - k stall cycles, k bubbles into MEM_WB.
  - Pipeline advances on the ready cycle.
  - Ready in the request cycle gives zero stalls.
- Timeout: the MAX_WAIT-th consecutive not-ready cycle still stalls normally. halted = 1 from the following cycle.
- Counter values are visible one cycle after the counted cycle.

## Test plan
- After reset, no hazards, 10 cycles -> all enables 1, flushes 0, stall_cnt = 0, flush_cnt = 0, state RUN.
- ex_mem_read = 1, ex_rd = 5, id_rs2 = 5, id_use_rs2 = 1 for 1 cycle -> pc_en = if_id_en = 0 and id_ex_flush = 1 that cycle; stall_cnt = 1 next cycle. Repeat with ex_rd = 0 -> no stall.
- Same load-use plus ex_br_taken = 1 in one cycle -> if_id_flush = id_ex_flush = 1, pc_en = 1; flush_cnt = 1, stall_cnt = 0.
- mem_req = 1, mem_ready low 3 cycles then high -> 3 cycles with ex_mem_en = 0 and mem_wb_flush = 1, state MEM_WAIT; on the ready cycle all enables 1 and state returns to RUN; stall_cnt = 3. Assert ex_br_taken during the wait -> no flush, flush_cnt unchanged.
- MAX_WAIT = 4, mem_ready held low -> 4 stall cycles, then halted = 1 with all enables 0. The state stays HALT while mem_ready rises. rst for 1 cycle -> RUN, counters 0.
- CW = 3, 9 load-use stalls -> stall_cnt stops at 7.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: combinational stage enables/flushes from load-use,
// taken-branch and data-memory wait hazards, plus timeout halt and saturating statistics.
module pipe_ctrl #(
    parameter int RW       = 5,
    parameter int CW       = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [RW-1:0] id_rs1,
    input  logic [RW-1:0] id_rs2,
    input  logic          id_use_rs1,
    input  logic          id_use_rs2,
    input  logic          ex_mem_read,
    input  logic [RW-1:0] ex_rd,
    input  logic          ex_br_taken,
    input  logic          mem_req,
    input  logic          mem_ready,
    output logic          pc_en,
    output logic          if_id_en,
    output logic          id_ex_en,
    output logic          ex_mem_en,
    output logic          mem_wb_en,
    output logic          if_id_flush,
    output logic          id_ex_flush,
    output logic          mem_wb_flush,
    output logic          halted,
    output logic [CW-1:0] stall_cnt,
    output logic [CW-1:0] flush_cnt
);

    typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, HALT = 2'd2} state_t;

    localparam int WW = $clog2(MAX_WAIT);
    localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

    state_t        state, state_nx;
    logic [WW-1:0] wait_cnt, wait_nx;
    logic          mstall, lu, stall_ev, flush_ev;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        mstall = mem_req & ~mem_ready & (state != HALT);
        lu = ex_mem_read & (ex_rd != '0) &
             ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        halted       = 1'b0;
        stall_ev     = 1'b0;
        flush_ev     = 1'b0;
        state_nx     = state;
        wait_nx      = wait_cnt;

        if (state == HALT) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
            halted    = 1'b1;
        end else if (mstall) begin
            // Upstream stages hold; MEM_WB takes a bubble while the access is outstanding.
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
            stall_ev     = 1'b1;
        end else if (ex_br_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_ev    = 1'b1;
        end else if (lu) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            stall_ev    = 1'b1;
        end

        if (state != HALT) begin
            if (mstall && wait_cnt == WAIT_LAST) begin
                state_nx = HALT;
            end else if (mstall) begin
                wait_nx  = wait_cnt + 1'b1;
                state_nx = MEM_WAIT;
            end else begin
                wait_nx  = '0;
                state_nx = RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_nx;
            if (stall_ev) stall_cnt <= sat_inc(stall_cnt);
            if (flush_ev) flush_cnt <= sat_inc(flush_cnt);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: two instances (default and small CW/MAX_WAIT) share directed and
// random stimulus and are compared every cycle against a behavioural hazard model.
module tb_pipe_ctrl;

    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] id_rs1, id_rs2, ex_rd;
    logic          id_use_rs1, id_use_rs2, ex_mem_read, ex_br_taken, mem_req, mem_ready;

    logic [8:0]  ctl0, ctl1;
    logic [31:0] sc0, fc0;
    logic [2:0]  sc1, fc1;

    int total  = 0;
    int passed = 0;

    // Model state per instance: 0 = CW 32 / MAX_WAIT 16, 1 = CW 3 / MAX_WAIT 4
    int     m_cw[2]   = '{32, 3};
    int     m_maxw[2] = '{16, 4};
    bit     m_halt[2];
    int     m_run[2];
    longint m_stall[2];
    longint m_flush[2];

    always #5 clk = ~clk;

    pipe_ctrl #(.RW(RW), .CW(32), .MAX_WAIT(16)) dut0 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .ex_br_taken(ex_br_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(ctl0[8]), .if_id_en(ctl0[7]), .id_ex_en(ctl0[6]), .ex_mem_en(ctl0[5]),
        .mem_wb_en(ctl0[4]), .if_id_flush(ctl0[3]), .id_ex_flush(ctl0[2]),
        .mem_wb_flush(ctl0[1]), .halted(ctl0[0]), .stall_cnt(sc0), .flush_cnt(fc0)
    );

    pipe_ctrl #(.RW(RW), .CW(3), .MAX_WAIT(4)) dut1 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .ex_br_taken(ex_br_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(ctl1[8]), .if_id_en(ctl1[7]), .id_ex_en(ctl1[6]), .ex_mem_en(ctl1[5]),
        .mem_wb_en(ctl1[4]), .if_id_flush(ctl1[3]), .id_ex_flush(ctl1[2]),
        .mem_wb_flush(ctl1[1]), .halted(ctl1[0]), .stall_cnt(sc1), .flush_cnt(fc1)
    );

    function automatic bit load_use();
        return ex_mem_read && ex_rd != 0 &&
               ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    endfunction

    // Expected controls: {pc,if_id,id_ex,ex_mem,mem_wb enables, if_id,id_ex,mem_wb flushes, halted}
    function automatic logic [8:0] exp_ctl(int i);
        if (m_halt[i])                 return 9'b00000_000_1;
        if (mem_req && !mem_ready)     return 9'b00001_001_0;
        if (ex_br_taken)               return 9'b11111_110_0;
        if (load_use())                return 9'b00111_010_0;
        return 9'b11111_000_0;
    endfunction

    function automatic logic [31:0] sat(longint v, int cw);
        longint top = (longint'(1) << cw) - 1;
        return 32'(v > top ? top : v);
    endfunction

    task automatic chk(string tag, int i, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s dut%0d t=%0t got=%0h want=%0h", tag, i, $time, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_halt[i] = 0; m_run[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
        end
    endtask

    task automatic model_edge();
        bit ms, lu;
        if (rst) begin
            model_reset();
            return;
        end
        lu = load_use();
        for (int i = 0; i < 2; i++) begin
            if (m_halt[i]) continue;
            ms = mem_req && !mem_ready;
            if (ms) begin
                m_stall[i]++;
                m_run[i]++;
                if (m_run[i] == m_maxw[i]) m_halt[i] = 1;
            end else begin
                m_run[i] = 0;
                if (ex_br_taken) m_flush[i]++;
                else if (lu)     m_stall[i]++;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        chk("ctl", 0, {23'b0, ctl0}, {23'b0, exp_ctl(0)});
        chk("ctl", 1, {23'b0, ctl1}, {23'b0, exp_ctl(1)});
        chk("stall_cnt", 0, sc0, sat(m_stall[0], 32));
        chk("stall_cnt", 1, {29'b0, sc1}, sat(m_stall[1], 3));
        chk("flush_cnt", 0, fc0, sat(m_flush[0], 32));
        chk("flush_cnt", 1, {29'b0, fc1}, sat(m_flush[1], 3));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_mem_read = 0; ex_rd = 0; ex_br_taken = 0; mem_req = 0; mem_ready = 0;
    endtask

    task automatic set_lu(logic [RW-1:0] rd);
        ex_mem_read = 1; ex_rd = rd; id_rs2 = 5; id_use_rs2 = 1;
    endtask

    initial begin
        idle();
        rst = 1;
        @(posedge clk); #1;
        model_reset();
        step(); step();
        rst = 0;
        repeat (10) step();

        // Load-use, then the same pattern against x0
        set_lu(5); step(); idle(); step();
        set_lu(0); step(); idle(); step();

        // Load-use coinciding with a taken branch
        set_lu(5); ex_br_taken = 1; step(); idle(); step();

        // Three not-ready cycles with a branch pending, then ready
        mem_req = 1; ex_br_taken = 1;
        repeat (3) step();
        mem_ready = 1; ex_br_taken = 0; step();
        idle(); step();

        // Ready in the request cycle
        mem_req = 1; mem_ready = 1; step(); idle(); step();

        // Timeout: small instance halts after 4, default keeps stalling
        mem_req = 1;
        repeat (6) step();
        mem_ready = 1; repeat (2) step();
        idle(); step();
        rst = 1; step(); rst = 0; step();

        // Saturation of the 3-bit stall counter
        for (int k = 0; k < 9; k++) begin
            set_lu(5); step(); idle(); step();
        end

        // Randomized traffic with occasional reset
        for (int k = 0; k < 400; k++) begin
            rst         = ($urandom_range(0, 59) == 0);
            id_rs1      = RW'($urandom_range(0, 3));
            id_rs2      = RW'($urandom_range(0, 3));
            ex_rd       = RW'($urandom_range(0, 3));
            id_use_rs1  = 1'($urandom);
            id_use_rs2  = 1'($urandom);
            ex_mem_read = 1'($urandom);
            ex_br_taken = ($urandom_range(0, 3) == 0);
            mem_req     = 1'($urandom);
            mem_ready   = ($urandom_range(0, 2) != 0);
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
